// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file between the Wishbone slave
// and a logic-analyzer requester; each transaction is sequenced IDLE->ISSUE->CAPTURE->ACK.
module regfile_arbiter #(
  parameter int unsigned ADDR_BITS = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic                 la_req_i,
  input  logic                 la_we_i,
  input  logic [3:0]           la_sel_i,
  input  logic [ADDR_BITS-1:0] la_adr_i,
  input  logic [31:0]          la_dat_i,
  output logic                 la_ack_o,
  output logic [31:0]          la_dat_o,
  output logic                 rf_en_o,
  output logic                 rf_we_o,
  output logic [3:0]           rf_sel_o,
  output logic [ADDR_BITS-1:0] rf_adr_o,
  output logic [31:0]          rf_wdata_o,
  input  logic [31:0]          rf_rdata_i,
  output logic                 grant_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StAck} state_e;

  state_e r_state;
  logic   r_owner;  // 0 = WB, 1 = LA
  logic   r_we;
  logic   r_ptr;    // side that wins the next tie

  logic                 w_wb_req;
  logic                 w_any;
  logic                 w_pick_la;
  logic                 w_wb_hit;
  logic                 w_mapped;
  logic                 w_req_we;
  logic [3:0]           w_req_sel;
  logic [ADDR_BITS-1:0] w_req_adr;
  logic [31:0]          w_req_wdata;
  logic                 w_owner_req;
  logic                 w_unused;

  assign w_wb_req    = wbs_cyc_i & wbs_stb_i;
  assign w_any       = w_wb_req | la_req_i;
  assign w_pick_la   = la_req_i & (~w_wb_req | r_ptr);
  assign w_wb_hit    = (wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign w_mapped    = w_pick_la | w_wb_hit;
  assign w_req_we    = w_pick_la ? la_we_i  : wbs_we_i;
  assign w_req_sel   = w_pick_la ? la_sel_i : wbs_sel_i;
  assign w_req_adr   = w_pick_la ? la_adr_i : wbs_adr_i[ADDR_BITS+1:2];
  assign w_req_wdata = w_pick_la ? la_dat_i : wbs_dat_i;
  assign w_owner_req = r_owner ? la_req_i : w_wb_req;
  assign w_unused    = ^wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= StIdle;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_ptr      <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      la_ack_o   <= 1'b0;
      la_dat_o   <= '0;
      rf_en_o    <= 1'b0;
      rf_we_o    <= 1'b0;
      rf_sel_o   <= '0;
      rf_adr_o   <= '0;
      rf_wdata_o <= '0;
      grant_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      // RF strobe and acks are single-cycle pulses; everything else holds unless set below
      rf_en_o    <= 1'b0;
      rf_we_o    <= 1'b0;
      rf_sel_o   <= '0;
      rf_adr_o   <= '0;
      rf_wdata_o <= '0;
      wbs_ack_o  <= 1'b0;
      la_ack_o   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner <= w_pick_la;
            r_we    <= w_req_we;
            r_ptr   <= ~w_pick_la;
            grant_o <= w_pick_la;
            busy_o  <= 1'b1;
            if (w_mapped) begin
              r_state    <= StIssue;
              rf_en_o    <= 1'b1;
              rf_we_o    <= w_req_we;
              rf_sel_o   <= w_req_we ? w_req_sel : 4'hF;
              rf_adr_o   <= w_req_adr;
              rf_wdata_o <= w_req_wdata;
            end else begin
              // Unmapped WB access: ack straight away, reads return zero
              r_state   <= StAck;
              wbs_ack_o <= 1'b1;
              if (!wbs_we_i) wbs_dat_o <= '0;
            end
          end
        end
        StIssue: begin
          if (r_we) begin
            r_state <= StAck;
            if (r_owner) la_ack_o  <= w_owner_req;
            else         wbs_ack_o <= w_owner_req;
          end else begin
            r_state <= StCapture;
          end
        end
        StCapture: begin
          r_state <= StAck;
          if (r_owner) begin
            la_dat_o <= rf_rdata_i;
            la_ack_o <= w_owner_req;
          end else begin
            wbs_dat_o <= rf_rdata_i;
            wbs_ack_o <= w_owner_req;
          end
        end
        StAck: begin
          r_state <= StIdle;
          busy_o  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios with literal expectations, then random
// traffic from both requesters checked every cycle against a transaction-schedule model.
module tb_regfile_arbiter;

  localparam int unsigned AB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = '0;
  logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          la_req_i = 1'b0, la_we_i = 1'b0;
  logic [3:0]    la_sel_i = '0;
  logic [AB-1:0] la_adr_i = '0;
  logic [31:0]   la_dat_i = '0;
  logic          la_ack_o;
  logic [31:0]   la_dat_o;
  logic          rf_en_o, rf_we_o;
  logic [3:0]    rf_sel_o;
  logic [AB-1:0] rf_adr_o;
  logic [31:0]   rf_wdata_o;
  logic [31:0]   rf_rdata;
  logic          grant_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.ADDR_BITS(AB), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_req_i(la_req_i), .la_we_i(la_we_i), .la_sel_i(la_sel_i),
    .la_adr_i(la_adr_i), .la_dat_i(la_dat_i), .la_ack_o(la_ack_o), .la_dat_o(la_dat_o),
    .rf_en_o(rf_en_o), .rf_we_o(rf_we_o), .rf_sel_o(rf_sel_o), .rf_adr_o(rf_adr_o),
    .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata), .grant_o(grant_o), .busy_o(busy_o)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-file array driven by the DUT's RF port (1-cycle registered read)
  logic [31:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_en_o) begin
      if (rf_we_o) rf_mem[rf_adr_o] <= merge(rf_mem[rf_adr_o], rf_wdata_o, rf_sel_o);
      else         rf_rdata <= rf_mem[rf_adr_o];
    end
  end

  // Reference model: each grant expands into a list of per-cycle expected outputs
  typedef struct packed {
    logic          en;
    logic          we;
    logic [3:0]    sel;
    logic [AB-1:0] adr;
    logic [31:0]   wdata;
    logic          ack_slot;
    logic          busy;
  } slot_t;

  slot_t       sched[$];
  logic [31:0] g_mem [16];
  logic        m_ptr, m_owner, m_is_read;
  logic [31:0] m_rdata;
  logic        e_rf_en, e_rf_we, e_busy, e_grant, e_wb_ack, e_la_ack;
  logic [3:0]  e_rf_sel;
  logic [AB-1:0] e_rf_adr;
  logic [31:0] e_rf_wdata, e_wb_dat, e_la_dat;

  always @(posedge clk or negedge rst_n) begin : model
    slot_t s;
    logic wbr, pick_la, mapped, we;
    logic [3:0] sel;
    logic [AB-1:0] adr;
    logic [31:0] wd;
    if (!rst_n) begin
      sched.delete();
      m_ptr = 1'b0; m_owner = 1'b0; m_is_read = 1'b0; m_rdata = '0;
      e_rf_en = 1'b0; e_rf_we = 1'b0; e_rf_sel = '0; e_rf_adr = '0; e_rf_wdata = '0;
      e_busy = 1'b0; e_grant = 1'b0; e_wb_ack = 1'b0; e_la_ack = 1'b0;
      e_wb_dat = '0; e_la_dat = '0;
    end else begin
      wbr = wbs_cyc_i & wbs_stb_i;
      if (sched.size() == 0 && (wbr || la_req_i)) begin
        pick_la = la_req_i && (!wbr || m_ptr);
        m_ptr   = !pick_la;
        m_owner = pick_la;
        e_grant = pick_la;
        we  = pick_la ? la_we_i  : wbs_we_i;
        sel = pick_la ? la_sel_i : wbs_sel_i;
        adr = pick_la ? la_adr_i : AB'((wbs_adr_i / 4) % 16);
        wd  = pick_la ? la_dat_i : wbs_dat_i;
        mapped = pick_la || ((wbs_adr_i >> (AB + 2)) == (32'h3000_0000 >> (AB + 2)));
        m_is_read = !we;
        if (!mapped) begin
          m_rdata = '0;
        end else begin
          sched.push_back('{en: 1'b1, we: we, sel: we ? sel : 4'hF, adr: adr, wdata: wd,
                            ack_slot: 1'b0, busy: 1'b1});
          if (we) begin
            g_mem[adr] = merge(g_mem[adr], wd, sel);
          end else begin
            m_rdata = g_mem[adr];
            sched.push_back('{en: 1'b0, we: 1'b0, sel: '0, adr: '0, wdata: '0,
                              ack_slot: 1'b0, busy: 1'b1});
          end
        end
        sched.push_back('{en: 1'b0, we: 1'b0, sel: '0, adr: '0, wdata: '0,
                          ack_slot: 1'b1, busy: 1'b1});
        sched.push_back('{en: 1'b0, we: 1'b0, sel: '0, adr: '0, wdata: '0,
                          ack_slot: 1'b0, busy: 1'b0});
      end
      if (sched.size() > 0) s = sched.pop_front();
      else s = '{en: 1'b0, we: 1'b0, sel: '0, adr: '0, wdata: '0, ack_slot: 1'b0, busy: 1'b0};
      e_rf_en = s.en; e_rf_we = s.we; e_rf_sel = s.sel; e_rf_adr = s.adr;
      e_rf_wdata = s.wdata; e_busy = s.busy;
      e_wb_ack = s.ack_slot && !m_owner && wbr;
      e_la_ack = s.ack_slot && m_owner && la_req_i;
      if (s.ack_slot && m_is_read) begin
        if (m_owner) e_la_dat = m_rdata;
        else         e_wb_dat = m_rdata;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (rst_n) begin
      chk("wbs_ack", 32'(wbs_ack_o), 32'(e_wb_ack));
      chk("la_ack", 32'(la_ack_o), 32'(e_la_ack));
      chk("wbs_dat", wbs_dat_o, e_wb_dat);
      chk("la_dat", la_dat_o, e_la_dat);
      chk("rf_en", 32'(rf_en_o), 32'(e_rf_en));
      chk("rf_we", 32'(rf_we_o), 32'(e_rf_we));
      chk("rf_sel", 32'(rf_sel_o), 32'(e_rf_sel));
      chk("rf_adr", 32'(rf_adr_o), 32'(e_rf_adr));
      chk("rf_wdata", rf_wdata_o, e_rf_wdata);
      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("busy", 32'(busy_o), 32'(e_busy));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wb_drive(input logic req, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
    wbs_cyc_i = req; wbs_stb_i = req; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
  endtask

  task automatic la_drive(input logic req, input logic we, input logic [3:0] sel,
                          input logic [AB-1:0] adr, input logic [31:0] dat);
    la_req_i = req; la_we_i = we; la_sel_i = sel; la_adr_i = adr; la_dat_i = dat;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wbs_ack"}, 32'(wbs_ack_o), 0);
    chk({tag, "_wbs_dat"}, wbs_dat_o, 0);
    chk({tag, "_la_ack"}, 32'(la_ack_o), 0);
    chk({tag, "_la_dat"}, la_dat_o, 0);
    chk({tag, "_rf_en"}, 32'(rf_en_o), 0);
    chk({tag, "_rf_we"}, 32'(rf_we_o), 0);
    chk({tag, "_rf_sel"}, 32'(rf_sel_o), 0);
    chk({tag, "_rf_adr"}, 32'(rf_adr_o), 0);
    chk({tag, "_rf_wdata"}, rf_wdata_o, 0);
    chk({tag, "_grant"}, 32'(grant_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  task automatic new_wb();
    wbs_we_i  = 1'($urandom_range(1, 0));
    wbs_sel_i = 4'($urandom);
    wbs_dat_i = $urandom;
    if ($urandom_range(7, 0) == 0) wbs_adr_i = $urandom;
    else wbs_adr_i = 32'h3000_0000 | 32'($urandom_range(63, 0));
  endtask

  task automatic new_la();
    la_we_i  = 1'($urandom_range(1, 0));
    la_sel_i = 4'($urandom);
    la_dat_i = $urandom;
    la_adr_i = AB'($urandom_range(15, 0));
  endtask

  initial begin : stim
    int ord [8];
    int n_acks;
    int rnd_acks;
    bit found, wb_act, la_act;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = '0;
      g_mem[i]  = '0;
    end
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // Mapped write: issue one cycle after the grant edge, ack after two
    wb_drive(1'b1, 1'b1, 4'hF, 32'h3000_0008, 32'hA5A5_1234);
    tick();
    chk("wr_rf_en", 32'(rf_en_o), 1);
    chk("wr_rf_we", 32'(rf_we_o), 1);
    chk("wr_rf_adr", 32'(rf_adr_o), 2);
    chk("wr_rf_wdata", rf_wdata_o, 32'hA5A5_1234);
    chk("wr_rf_sel", 32'(rf_sel_o), 32'hF);
    chk("wr_ack_early", 32'(wbs_ack_o), 0);
    tick();
    chk("wr_ack", 32'(wbs_ack_o), 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("wr_idle_busy", 32'(busy_o), 0);

    // Mapped read: data with ack three cycles after the grant edge
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
    tick();
    chk("rd_rf_en", 32'(rf_en_o), 1);
    chk("rd_rf_we", 32'(rf_we_o), 0);
    chk("rd_rf_sel", 32'(rf_sel_o), 32'hF);
    tick();
    chk("rd_ack_capture", 32'(wbs_ack_o), 0);
    tick();
    chk("rd_ack", 32'(wbs_ack_o), 1);
    chk("rd_dat", wbs_dat_o, 32'hA5A5_1234);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // Partial byte write then readback
    wb_drive(1'b1, 1'b1, 4'h2, 32'h3000_0008, 32'hFFFF_FFFF);
    tick();
    chk("sel2_rf_sel", 32'(rf_sel_o), 32'h2);
    tick();
    chk("sel2_ack", 32'(wbs_ack_o), 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
    tick(); tick(); tick();
    chk("sel2_rd_dat", wbs_dat_o, 32'hA5A5_FF34);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // Unmapped read: immediate ack, zero data, no RF access
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3100_0000, 32'h0);
    tick();
    chk("unm_ack", 32'(wbs_ack_o), 1);
    chk("unm_rf_en", 32'(rf_en_o), 0);
    chk("unm_dat", wbs_dat_o, 0);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("unm_busy_after", 32'(busy_o), 0);

    // LA write abandoned during ISSUE: write lands, no ack
    la_drive(1'b1, 1'b1, 4'hF, 4'd5, 32'h1111_2222);
    tick();
    chk("la_rf_en", 32'(rf_en_o), 1);
    chk("la_rf_adr", 32'(rf_adr_o), 5);
    chk("la_grant", 32'(grant_o), 1);
    la_drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    chk("la_drop_ack", 32'(la_ack_o), 0);
    tick();
    chk("la_drop_busy", 32'(busy_o), 0);
    chk("la_drop_mem", rf_mem[5], 32'h1111_2222);

    // Both requesters held after reset: grants alternate starting with WB
    #2 rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
    la_drive(1'b1, 1'b0, 4'hF, 4'd5, 32'h0);
    for (int i = 0; i < 8; i++) ord[i] = -1;
    n_acks = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("alt_both_ack", 32'(wbs_ack_o & la_ack_o), 0);
      if (wbs_ack_o || la_ack_o) begin
        if (n_acks < 8) ord[n_acks] = la_ack_o ? 1 : 0;
        n_acks++;
        chk("alt_grant", 32'(grant_o), 32'(la_ack_o));
        if (wbs_ack_o) chk("alt_wb_dat", wbs_dat_o, 32'hA5A5_FF34);
        if (la_ack_o)  chk("alt_la_dat", la_dat_o, 32'h1111_2222);
      end
    end
    chk("alt_n_acks", 32'(n_acks >= 4), 1);
    for (int i = 0; i < 4; i++) chk("alt_order", 32'(ord[i]), 32'(i % 2));
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    la_drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick(); tick(); tick(); tick();

    // Reset during CAPTURE, then pending WB read wins the first tie
    wb_drive(1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
    tick();
    tick();
    la_drive(1'b1, 1'b0, 4'hF, 4'd5, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    tick();
    #2 rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      if (wbs_ack_o || la_ack_o) begin
        found = 1'b1;
        chk("rst_first_wb_ack", 32'(wbs_ack_o), 1);
        chk("rst_first_la_ack", 32'(la_ack_o), 0);
        chk("rst_wb_dat", wbs_dat_o, 32'hA5A5_FF34);
      end
    end
    if (!found) chk("rst_resume_timeout", 0, 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    la_drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick(); tick(); tick(); tick();

    // Random traffic from both sides, checked cycle by cycle against the model
    wb_act = 1'b0; la_act = 1'b0; rnd_acks = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (wbs_ack_o || la_ack_o) rnd_acks++;
      if (wb_act) begin
        if (wbs_ack_o) begin
          if ($urandom_range(1, 0) == 0) wb_act = 1'b0;
          else new_wb();
        end else if ($urandom_range(29, 0) == 0) wb_act = 1'b0;
        else if ($urandom_range(7, 0) == 0) new_wb();
      end else if ($urandom_range(2, 0) == 0) begin
        wb_act = 1'b1;
        new_wb();
      end
      wbs_stb_i = wb_act;
      wbs_cyc_i = wb_act | ($urandom_range(3, 0) == 0);
      if (la_act) begin
        if (la_ack_o) begin
          if ($urandom_range(1, 0) == 0) la_act = 1'b0;
          else new_la();
        end else if ($urandom_range(29, 0) == 0) la_act = 1'b0;
        else if ($urandom_range(7, 0) == 0) new_la();
      end else if ($urandom_range(2, 0) == 0) begin
        la_act = 1'b1;
        new_la();
      end
      la_req_i = la_act;
    end
    chk("rand_acks_seen", 32'(rnd_acks > 100), 1);
    wb_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    la_drive(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick(); tick(); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Shares one single-port 16x32 register file between two requesters: the Wishbone slave interface (management SoC) and a logic-analyzer-driven requester. Each transaction is arbitrated round-robin and sequenced through the RF port, which has a 1-cycle registered read. The requester gets a one-cycle ack with read data. Sits between the user-project Wishbone/LA pins and the register file array.

Parameters:
ADDR_BITS, 4, RF word-address width (2^ADDR_BITS words)
BASE_ADDR, 32'h3000_0000, Wishbone byte base address; bits [31:ADDR_BITS+2] decoded

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  WB cycle
wbs_stb_i  in  1  WB strobe; request = cyc & stb
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte lanes
wbs_adr_i  in  32  WB byte address
wbs_dat_i  in  32  WB write data
wbs_ack_o  out  1  WB ack, one cycle
wbs_dat_o  out  32  WB read data, valid with ack
la_req_i  in  1  LA request, level, held until ack
la_we_i  in  1  LA write enable
la_sel_i  in  4  LA byte lanes
la_adr_i  in  ADDR_BITS  LA word address
la_dat_i  in  32  LA write data
la_ack_o  out  1  LA ack, one cycle
la_dat_o  out  32  LA read data, valid with ack
rf_en_o  out  1  RF access strobe
rf_we_o  out  1  RF write
rf_sel_o  out  4  RF byte-lane write enables
rf_adr_o  out  ADDR_BITS  RF word address
rf_wdata_o  out  32  RF write data
rf_rdata_i  in  32  RF read data, valid the cycle after rf_en_o & ~rf_we_o
grant_o  out  1  owner of current/last transaction (0=WB, 1=LA)
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; priority pointer = WB.
- States: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: sample requests. If none, stay. If one, grant it. If both, grant the side the pointer names, then point the pointer at the other side. Single-requester grants also move the pointer to the other side. Latch owner, we, sel, word address, wdata into internal regs.
- WB address decode: word address = wbs_adr_i[ADDR_BITS+1:2]. If wbs_adr_i[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2], the access is unmapped: skip ISSUE, go IDLE->ACK, drive no rf_en_o, and return read data 0. Writes are dropped.
- ISSUE (1 cycle): rf_en_o=1, rf_we_o=latched we, rf_adr_o/rf_wdata_o from latches. rf_sel_o = latched sel on writes and 4'hF on reads. Write -> ACK. Read -> CAPTURE.
- CAPTURE (1 cycle): register rf_rdata_i into the owner's dat_o -> ACK.
- ACK (1 cycle): assert owner's ack -> IDLE. dat_o holds its value until the next read completes for that requester.
- Latency from the request sampling edge to the ack cycle: mapped write 2 cycles, mapped read 3 cycles, unmapped 1 cycle. A new grant is possible at the earliest in the IDLE cycle following ACK, so a request still high in that cycle is treated as new.
- A write with sel=4'b0000 still issues (rf_sel_o=0, no bytes change) and acks.
- Requester drops its request before ACK: the transaction completes internally (any issued write stands) and the ack is suppressed for that cycle. The FSM still returns to IDLE.
- The non-granted requester waits with no ack; its inputs may change freely until granted.
- rf_en_o is never asserted outside ISSUE. rf_en_o is never high two consecutive cycles.
- Reset mid-transaction: immediate IDLE; ack and rf_en_o go low; partially issued write behaviour is the RF's concern.
- grant_o updates on the grant edge. busy_o=1 in ISSUE/CAPTURE/ACK.

Test Plan:
- WB write adr 0x3000_0008, data 0xA5A5_1234, sel 4'hF -> rf_en_o/rf_we_o high with rf_adr_o=2 one cycle after the grant edge; wbs_ack_o two cycles after the grant edge.
- WB read adr 0x3000_0008, RF model returns 0xA5A5_1234 -> wbs_dat_o=0xA5A5_1234 with wbs_ack_o three cycles after the grant edge. Also run with sel=4'h2 write of 0xFFFF_FFFF -> rf_sel_o=4'h2.
- WB and LA both request reads from reset, held after ack -> grants alternate WB, LA, WB, LA; grant_o toggles; no cycle has both acks high.
- WB access to 0x3100_0000 -> no rf_en_o; wbs_ack_o one cycle after the grant edge; wbs_dat_o=0.
- LA write with la_req_i dropped during ISSUE -> rf write occurs, la_ack_o never asserts, busy_o=0 two cycles later.
- wb_rst_n_i pulsed low during CAPTURE -> all outputs 0 at once. After release, a pending WB read completes normally and WB wins the first tie.
